pulse_sequencer: RTL



---
 rtl/pulse_seq_pkg.sv | 29 ++
 rtl/pulse_sequencer_timer.sv | 29 ++
 rtl/pulse_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequencer: FSM state encoding, default
// field widths and the width of the single state timer.
package pulse_seq_pkg;

   localparam int PER_W_DEF = 32;
   localparam int T_W_DEF   = 16;
   // 2*tau needs one bit more than a width/delay field.
   localparam int ECHO_W    = T_W_DEF + 1;

   typedef enum logic [2:0] {
      IDLE,
      NUT,
      ND,
      P1,
      D1,
      P2,
      D2,
      TAIL
   } seq_state_t;

   function automatic logic is_pulse_state(input seq_state_t s);
      return (s == NUT) || (s == P1) || (s == P2);
   endfunction

   function automatic logic is_busy_state(input seq_state_t s);
      return (s != IDLE) && (s != TAIL);
   endfunction

endpackage

// File: rtl/pulse_sequencer_timer.sv
// Loadable down-counter shared by every timed state of the sequencer.
// A state of length L loads L-1; done flags the final cycle of that state.
module pulse_timer
   import pulse_seq_pkg::*;
#(
   parameter int W = ECHO_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Spin-echo / CPMG pulse train sequencer with per-period parameter shadowing.
// Optional nutation pre-pulse is built when PULSE_SEQ_NUTATION_EN is defined.
module pulse_sequencer
   import pulse_seq_pkg::*;
#(
   parameter int PER_W = PER_W_DEF,
   parameter int T_W   = T_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [PER_W-1:0] per,
   input  logic [T_W-1:0]   p1wid,
   input  logic [T_W-1:0]   del,
   input  logic [T_W-1:0]   p2wid,
   input  logic [7:0]       cp,
   input  logic [7:0]       p_bl,
   input  logic             bl,
   input  logic [7:0]       nut_w,
   input  logic [T_W-1:0]   nut_d,
   output logic             pulse,
   output logic             blank,
   output logic             sync,
   output logic             busy
);

   localparam int LW = T_W + 1;

   seq_state_t state, state_next;

   logic [PER_W-1:0] cnt, sper, lim;
   logic             running, hold, period_start, start, stop;

   logic [T_W-1:0]   sp1, sdel, sp2;
   logic [7:0]       scp, sp_bl;
   logic             sbl;

   logic [T_W-1:0]   p1_e, del_e, p2_e;
   logic [7:0]       cp_e, p_bl_e;
   logic             bl_e;

   logic [7:0]       n, n_next, n_inc;
   logic [7:0]       hcnt, hcnt_next;
   logic             pulse_next, blank_next;

   logic             tmr_load, tmr_done;
   logic [LW-1:0]    tmr_val;

   logic             e_p1, e_d1, e_p2, e_d2;

`ifdef PULSE_SEQ_NUTATION_EN
   logic [7:0]       snut_w, nut_w_e;
   logic [T_W-1:0]   snut_d, nut_d_e;
   logic             e_nut, e_nd;
`else
   logic             unused_nut;
   assign unused_nut = ^{nut_w, nut_d};
`endif

   // per < 2 parks everything; the running period length comes from the shadow.
   assign hold         = (per < PER_W'(2));
   assign period_start = !hold && (cnt == '0);
   assign start        = period_start && en;
   assign stop         = period_start && !en;
   assign lim          = running ? sper : per;

   always_ff @(posedge clk) begin
      if (rst || hold) begin
         cnt <= '0;
      end else if (cnt >= lim - PER_W'(1)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + PER_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         running <= 1'b0;
         sper    <= '0;
         sp1     <= '0;
         sdel    <= '0;
         sp2     <= '0;
         scp     <= '0;
         sp_bl   <= '0;
         sbl     <= 1'b0;
`ifdef PULSE_SEQ_NUTATION_EN
         snut_w  <= '0;
         snut_d  <= '0;
`endif
      end else if (hold || stop) begin
         running <= 1'b0;
      end else if (start) begin
         running <= 1'b1;
         sper    <= per;
         sp1     <= p1wid;
         sdel    <= del;
         sp2     <= p2wid;
         scp     <= cp;
         sp_bl   <= p_bl;
         sbl     <= bl;
`ifdef PULSE_SEQ_NUTATION_EN
         snut_w  <= nut_w;
         snut_d  <= nut_d;
`endif
      end
   end

   // During the launch cycle the shadows are still loading, so use the live inputs.
   assign p1_e   = start ? p1wid : sp1;
   assign del_e  = start ? del   : sdel;
   assign p2_e   = start ? p2wid : sp2;
   assign cp_e   = start ? cp    : scp;
   assign p_bl_e = start ? p_bl  : sp_bl;
   assign bl_e   = start ? bl    : sbl;
`ifdef PULSE_SEQ_NUTATION_EN
   assign nut_w_e = start ? nut_w : snut_w;
   assign nut_d_e = start ? nut_d : snut_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         n     <= '0;
      end else begin
         state <= state_next;
         n     <= n_next;
      end
   end

   always_comb begin
      state_next = state;
      n_next     = n;
      n_inc      = n + 8'd1;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      e_p1       = 1'b0;
      e_d1       = 1'b0;
      e_p2       = 1'b0;
      e_d2       = 1'b0;
`ifdef PULSE_SEQ_NUTATION_EN
      e_nut      = 1'b0;
      e_nd       = 1'b0;
`endif

      if (hold || stop) begin
         state_next = IDLE;
         n_next     = '0;
      end else if (start) begin
         n_next = '0;
`ifdef PULSE_SEQ_NUTATION_EN
         e_nut  = 1'b1;
`else
         e_p1   = 1'b1;
`endif
      end else begin
         case (state)
`ifdef PULSE_SEQ_NUTATION_EN
            NUT: if (tmr_done) e_nd = 1'b1;
            ND:  if (tmr_done) e_p1 = 1'b1;
`endif
            P1:  if (tmr_done) e_d1 = 1'b1;
            D1:  if (tmr_done) e_p2 = 1'b1;
            P2: begin
               if (tmr_done) begin
                  n_next = n_inc;
                  if (n_inc < cp_e) e_d2 = 1'b1;
                  else              state_next = TAIL;
               end
            end
            D2:  if (tmr_done) e_p2 = 1'b1;
            default: ;
         endcase
      end

      // Entry requests cascade so zero-length states are skipped in the same cycle.
`ifdef PULSE_SEQ_NUTATION_EN
      if (e_nut) begin
         if (nut_w_e != 8'd0) begin
            state_next = NUT;
            tmr_load   = 1'b1;
            tmr_val    = LW'(nut_w_e) - LW'(1);
         end else begin
            e_p1 = 1'b1;
         end
      end
      if (e_nd) begin
         if (nut_d_e != '0) begin
            state_next = ND;
            tmr_load   = 1'b1;
            tmr_val    = {1'b0, nut_d_e} - LW'(1);
         end else begin
            e_p1 = 1'b1;
         end
      end
`endif
      if (e_p1) begin
         if (p1_e != '0) begin
            state_next = P1;
            tmr_load   = 1'b1;
            tmr_val    = {1'b0, p1_e} - LW'(1);
         end else begin
            e_d1 = 1'b1;
         end
      end
      if (e_d1) begin
         if (del_e != '0) begin
            state_next = D1;
            tmr_load   = 1'b1;
            tmr_val    = {1'b0, del_e} - LW'(1);
         end else begin
            e_p2 = 1'b1;
         end
      end
      if (e_p2) begin
         if ((cp_e == 8'd0) || (p2_e == '0)) begin
            state_next = TAIL;
         end else begin
            state_next = P2;
            tmr_load   = 1'b1;
            tmr_val    = {1'b0, p2_e} - LW'(1);
         end
      end
      if (e_d2) begin
         if (del_e != '0) begin
            state_next = D2;
            tmr_load   = 1'b1;
            tmr_val    = {del_e, 1'b0} - LW'(1);
         end else begin
            state_next = P2;
            tmr_load   = 1'b1;
            tmr_val    = {1'b0, p2_e} - LW'(1);
         end
      end
   end

   pulse_timer #(
      .W (LW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Blanking hold-off restarts on every pulse cycle, so close pulses merge.
   assign pulse_next = is_pulse_state(state_next);
   assign blank_next = bl_e && !hold && (pulse_next || (hcnt != 8'd0));

   always_comb begin
      hcnt_next = '0;
      if (hold) begin
         hcnt_next = '0;
      end else if (pulse_next) begin
         hcnt_next = p_bl_e;
      end else if (hcnt != 8'd0) begin
         hcnt_next = hcnt - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pulse <= 1'b0;
         blank <= 1'b0;
         sync  <= 1'b0;
         busy  <= 1'b0;
         hcnt  <= '0;
      end else begin
         pulse <= pulse_next;
         blank <= blank_next;
         sync  <= start;
         busy  <= is_busy_state(state_next);
         hcnt  <= hcnt_next;
      end
   end

endmodule
